// File: rtl/canframegen_sched_pkg.sv
// rtl/canframegen_sched_pkg.sv - shared types and helpers for the CAN frame generator scheduler
package canframegen_sched_pkg;

    localparam int TYPE_W = 3;

    typedef enum logic [TYPE_W-1:0] {
        T_READ    = 3'd0,
        T_WRITE   = 3'd1,
        T_READADC = 3'd2,
        T_RSTCHIP = 3'd3,
        T_CUSTOM  = 3'd4
    } req_type_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARB      = 3'd1,
        ST_SETUP    = 3'd2,
        ST_SEND     = 3'd3,
        ST_WAIT_RSP = 3'd4,
        ST_GAP      = 3'd5
    } state_e;

    // Strobe vector ordering: {custom, rstchip, readadc, write, read}
    function automatic logic [4:0] type_strobes(input logic [TYPE_W-1:0] t);
        logic [4:0] s;
        s = 5'b00000;
        case (t)
            T_READ:    s = 5'b00001;
            T_WRITE:   s = 5'b00010;
            T_READADC: s = 5'b00100;
            T_RSTCHIP: s = 5'b01000;
            T_CUSTOM:  s = 5'b10000;
            default:   s = 5'b00000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/canframegen_sched_rr_arbiter.sv
// rtl/canframegen_sched_rr_arbiter.sv - combinational round-robin pick starting after ptr
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [PTR_W-1:0] idx,
    output logic             valid
);

    logic [PTR_W-1:0] j;

    // Walk from the farthest candidate to the nearest so the nearest set request wins
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        j     = '0;
        for (int i = NREQ; i >= 1; i--) begin
            j = PTR_W'((int'(ptr) + i) % NREQ);
            if (req[j]) begin
                grant = NREQ'(1) << j;
                idx   = j;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/canframegen_sched.sv
// rtl/canframegen_sched.sv - shares one CAN frame generator between NREQ requesters
module canframegen_sched
    import canframegen_sched_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int SETUP_CYC = 4,
    parameter int EOF_BITS  = 10,
    parameter int TX_TO     = 200,
    parameter int RSP_TO    = 400,
    parameter int IFS_BITS  = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     bit_tick,
    input  logic [NREQ-1:0]          req,
    input  logic [TYPE_W*NREQ-1:0]   req_type,
    input  logic [24*NREQ-1:0]       req_index,
    input  logic [64*NREQ-1:0]       req_data,
    output logic [NREQ-1:0]          grant,
    output logic [NREQ-1:0]          done,
    output logic [NREQ-1:0]          err,
    output logic                     busy,
    output logic                     gen_start,
    output logic                     gen_read,
    output logic                     gen_write,
    output logic                     gen_rstchip,
    output logic                     gen_readadc,
    output logic                     gen_custommsg,
    output logic [23:0]              gen_indexsubindex,
    output logic [63:0]              gen_data,
    output logic [31:0]              gen_taildata,
    input  logic                     txgen,
    input  logic                     rsp_valid
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [2:0] S_IDLE     = 3'(ST_IDLE);
    localparam logic [2:0] S_ARB      = 3'(ST_ARB);
    localparam logic [2:0] S_SETUP    = 3'(ST_SETUP);
    localparam logic [2:0] S_SEND     = 3'(ST_SEND);
    localparam logic [2:0] S_WAIT_RSP = 3'(ST_WAIT_RSP);
    localparam logic [2:0] S_GAP      = 3'(ST_GAP);

    logic [2:0]        state;
    logic [PTR_W-1:0]  ptr;
    logic [TYPE_W-1:0] lat_type;
    logic [4:0]        strb;
    logic [15:0]       tcnt;
    logic [15:0]       rec_cnt;
    logic              sof_seen;

    logic [NREQ-1:0]   arb_grant;
    logic [PTR_W-1:0]  arb_idx;
    logic              arb_valid;

    logic [TYPE_W-1:0] win_type;
    logic [23:0]       win_index;
    logic [63:0]       win_data;

    logic [15:0]       tcnt_inc;
    logic [15:0]       rec_inc;
    logic              eof_hit;

    rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // One-hot mux of the winning requester's command fields
    always_comb begin
        win_type  = '0;
        win_index = '0;
        win_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_grant[i]) begin
                win_type  = req_type[i*TYPE_W +: TYPE_W];
                win_index = req_index[i*24 +: 24];
                win_data  = req_data[i*64 +: 64];
            end
        end
    end

    assign tcnt_inc = (&tcnt)    ? tcnt    : tcnt + 16'd1;
    assign rec_inc  = (&rec_cnt) ? rec_cnt : rec_cnt + 16'd1;
    assign eof_hit  = sof_seen && txgen && (rec_inc >= 16'(EOF_BITS));

    assign busy          = (state != S_IDLE);
    assign gen_read      = strb[0];
    assign gen_write     = strb[1];
    assign gen_readadc   = strb[2];
    assign gen_rstchip   = strb[3];
    assign gen_custommsg = strb[4];

    // Transaction sequencer: arbitrate, set up, send, await response, inter-frame gap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= S_IDLE;
            ptr               <= PTR_W'(NREQ - 1);
            grant             <= '0;
            done              <= '0;
            err               <= '0;
            strb              <= '0;
            gen_start         <= 1'b0;
            lat_type          <= '0;
            gen_indexsubindex <= '0;
            gen_data          <= '0;
            gen_taildata      <= '0;
            tcnt              <= '0;
            rec_cnt           <= '0;
            sof_seen          <= 1'b0;
        end else begin
            done <= '0;
            err  <= '0;
            case (state)
                S_IDLE: begin
                    if (|req) state <= S_ARB;
                end
                S_ARB: begin
                    tcnt <= '0;
                    if (!arb_valid) begin
                        state <= S_IDLE;
                    end else begin
                        grant             <= arb_grant;
                        ptr               <= arb_idx;
                        lat_type          <= win_type;
                        gen_indexsubindex <= win_index;
                        gen_data          <= win_data;
                        gen_taildata      <= win_data[31:0];
                        if (win_type > 3'(T_CUSTOM)) begin
                            err   <= arb_grant;
                            state <= S_GAP;
                        end else begin
                            strb  <= type_strobes(win_type);
                            state <= S_SETUP;
                        end
                    end
                end
                S_SETUP: begin
                    if (tcnt_inc >= 16'(SETUP_CYC)) begin
                        gen_start <= 1'b1;
                        tcnt      <= '0;
                        rec_cnt   <= '0;
                        sof_seen  <= 1'b0;
                        state     <= S_SEND;
                    end else begin
                        tcnt <= tcnt_inc;
                    end
                end
                S_SEND: begin
                    if (bit_tick) begin
                        if (eof_hit) begin
                            gen_start <= 1'b0;
                            strb      <= '0;
                            tcnt      <= '0;
                            if (lat_type == 3'(T_RSTCHIP)) begin
                                done  <= grant;
                                state <= S_GAP;
                            end else begin
                                state <= S_WAIT_RSP;
                            end
                        end else if (tcnt_inc >= 16'(TX_TO)) begin
                            gen_start <= 1'b0;
                            strb      <= '0;
                            tcnt      <= '0;
                            err       <= grant;
                            state     <= S_GAP;
                        end else begin
                            tcnt <= tcnt_inc;
                            if (!txgen) begin
                                sof_seen <= 1'b1;
                                rec_cnt  <= '0;
                            end else if (sof_seen) begin
                                rec_cnt <= rec_inc;
                            end
                        end
                    end
                end
                S_WAIT_RSP: begin
                    if (rsp_valid) begin
                        done  <= grant;
                        tcnt  <= '0;
                        state <= S_GAP;
                    end else if (bit_tick) begin
                        if (tcnt_inc >= 16'(RSP_TO)) begin
                            err   <= grant;
                            tcnt  <= '0;
                            state <= S_GAP;
                        end else begin
                            tcnt <= tcnt_inc;
                        end
                    end
                end
                S_GAP: begin
                    if (bit_tick) begin
                        if (tcnt_inc >= 16'(IFS_BITS)) begin
                            grant <= '0;
                            tcnt  <= '0;
                            state <= S_IDLE;
                        end else begin
                            tcnt <= tcnt_inc;
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    grant     <= '0;
                    strb      <= '0;
                    gen_start <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/canframegen_sched.md
Name: canframegen_sched

Overview:
- Single-clock scheduler that shares one MOPS CAN frame generator between NREQ requesters.
- Arbitrates requests round-robin and latches the winner's command and payload.
- Drives the generator's command strobes and start, monitors txgen for end of frame, waits for the DUT response, enforces inter-frame space, then reports done or error to the winner.
- Sits in the mopshub testbench between the test sequencer(s) and the frame generator.

Parameters:
- NREQ, 4, number of requesters (2..8)
- SETUP_CYC, 4, clk cycles commands are held stable before start rises
- EOF_BITS, 10, consecutive recessive bit_ticks after SOF that mark end of frame
- TX_TO, 200, bit_tick limit for SEND before error
- RSP_TO, 400, bit_tick limit for WAIT_RSP before error
- IFS_BITS, 3, bit_ticks of idle after a transaction

Ports:
- clk  in  1  main clock
- rst_n  in  1  asynchronous active-low reset
- bit_tick  in  1  one-clk pulse per CAN bit time
- req  in  NREQ  request level per requester; held until done/err
- req_type  in  3*NREQ  per-requester type: 0 READ, 1 WRITE, 2 READADC, 3 RSTCHIP, 4 CUSTOM
- req_index  in  24*NREQ  index/subindex
- req_data  in  64*NREQ  custom payload; bits [31:0] are write tail data
- grant  out  NREQ  one-hot, held for whole transaction
- done  out  NREQ  one-clk success pulse
- err  out  NREQ  one-clk failure pulse
- busy  out  1  state != IDLE
- gen_start, gen_read, gen_write, gen_rstchip, gen_readadc, gen_custommsg  out  1 each  generator controls
- gen_indexsubindex  out  24  latched index
- gen_data  out  64  latched payload
- gen_taildata  out  32  latched req_data[31:0]
- txgen  in  1  generator serial output, monitored
- rsp_valid  in  1  one-clk pulse when a DUT response frame is received

Behaviour:
- Reset (async, rst_n low): state IDLE; grant, done, err, busy, all gen_* strobes and gen_start = 0; buses = 0; rr pointer = NREQ-1.
- IDLE: if any req is set, go to ARB next clk.
- ARB (1 clk):
  - Pick the first requester searching from ptr+1 modulo NREQ.
  - Set grant, update ptr, latch type, index and data.
  - Illegal type (5..7): err pulse for the winner next clk, then go to GAP; no strobes are driven.
- SETUP:
  - Exactly one strobe matching the latched type is asserted; gen_start = 0.
  - Lasts SETUP_CYC clks, then go to SEND.
- SEND:
  - gen_start = 1 and the strobe is held.
  - On bit_tick: a low txgen sets sof_seen and clears the recessive counter; a high txgen after sof_seen increments it.
  - Counter reaching EOF_BITS ends SEND: drop gen_start and all strobes.
  - RSTCHIP goes to GAP with a done pulse; all other types go to WAIT_RSP.
  - tx_cnt reaching TX_TO, or no SOF within TX_TO: drop everything, err pulse, go to GAP.
- WAIT_RSP:
  - rsp_valid gives a done pulse and goes to GAP.
  - rsp_cnt reaching RSP_TO ticks gives an err pulse and goes to GAP.
  - If rsp_valid and the timeout occur in the same clk, rsp_valid wins.
- GAP:
  - Count IFS_BITS bit_ticks, then clear grant and go to IDLE.
  - grant stays asserted through the done/err pulse.
- done/err fire in the clk after the causing event and are mutually exclusive.
- A requester dropping req mid-transaction is ignored: the transaction completes and done/err is still pulsed.
- New requests are only evaluated in IDLE.
- Tick counters are 16-bit and saturate.
- bit_tick coincident with a state change is consumed by the new state only.

Decomposition:
- Package canframegen_sched_pkg:
  - typedef enum for req types (READ..CUSTOM)
  - typedef enum for states IDLE, ARB, SETUP, SEND, WAIT_RSP, GAP
  - TYPE_W = 3
- One sub-module: rr_arbiter (NREQ req in, ptr in, one-hot grant out, combinational), instantiated once.

Test Plan:
- Reset mid-SEND (rst_n low with gen_start=1) -> next clk all outputs 0, state IDLE; after release, a new req restarts from ARB.
- Single req[0], type READ, index 24'h201000 -> gen_read=1 and gen_indexsubindex=24'h201000 for 4 clks before gen_start; after SOF plus 10 recessive ticks gen_start=0; rsp_valid at tick 50 -> done[0] pulse, grant[0] held through GAP 3 ticks.
- req = 4'b1111 continuously, all WRITE -> grants in order 0,1,2,3,0, each with gen_taildata = that requester's req_data[31:0].
- Type RSTCHIP on req[2] -> done[2] right after EOF detection, with no WAIT_RSP (rsp_valid never asserted).
- READADC with no rsp_valid -> err[1] exactly at 400 ticks after SEND exit; txgen held 1 throughout SEND -> err at 200 ticks.
- Illegal type 3'd6 -> err pulse 2 clks after req, no gen_* strobe ever asserted.
